// File: rtl/hall_call_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : hall_call_dispatcher
// Description : Latches up/down hall-call buttons into a call table, scans the
//               table round-robin, picks the cheapest enabled lift for each
//               unassigned call and offers it over a valid/ready handshake.
//               A call clears when its owning lift opens doors at its floor.
// Revision    : 1.0 - initial release
// ============================================================================
module hall_call_dispatcher #(
    parameter  int N_FLOORS = 12,
    parameter  int N_LIFTS  = 10,
    localparam int FW       = $clog2(N_FLOORS),
    localparam int LW       = $clog2(N_LIFTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_FLOORS-1:0]           up_rqst,
    input  logic [N_FLOORS-1:0]           dn_rqst,
    input  logic [N_LIFTS-1:0][FW-1:0]    lift_floor,
    input  logic [N_LIFTS-1:0]            direction,
    input  logic [N_LIFTS-1:0]            motion,
    input  logic [N_LIFTS-1:0]            door_open,
    input  logic [N_LIFTS-1:0]            lift_enable,
    output logic                          assign_valid,
    input  logic                          assign_ready,
    output logic [LW-1:0]                 assign_lift,
    output logic [FW-1:0]                 assign_floor,
    output logic                          assign_up,
    output logic [N_FLOORS-1:0]           pending_up,
    output logic [N_FLOORS-1:0]           pending_dn
);

    // Call table: entries 0..N_FLOORS-1 are up calls, the rest are down calls.
    localparam int                   NC         = 2 * N_FLOORS;
    localparam int                   CW         = $clog2(NC);
    localparam int                   CSTW       = FW + 1;
    localparam logic [N_FLOORS-1:0]  UP_MASK    = {1'b0, {(N_FLOORS-1){1'b1}}};
    localparam logic [N_FLOORS-1:0]  DN_MASK    = {{(N_FLOORS-1){1'b1}}, 1'b0};
    localparam logic [CSTW-1:0]      PENALTY    = CSTW'(N_FLOORS);
    localparam logic [FW-1:0]        LAST_FLOOR = FW'(N_FLOORS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_EVAL  = 2'd2,
        ST_OFFER = 2'd3
    } state_t;

    state_t             state_q;
    logic               valid_q;
    logic [LW-1:0]      lift_q;
    logic [FW-1:0]      floor_q;
    logic               up_q;

    // Scan pointer kept as {direction, floor} so no division is ever needed.
    logic               ptr_dn_q;
    logic [FW-1:0]      ptr_fl_q;
    logic               w_ptr_dn_nxt;
    logic [FW-1:0]      w_ptr_fl_nxt;
    logic [CW-1:0]      w_ptr_idx;

    logic [NC-1:0]      pend_q, pend_d;
    logic [NC-1:0]      asg_q,  asg_d;
    logic [LW-1:0]      owner_q [NC];
    logic [LW-1:0]      owner_d [NC];

    logic [NC-1:0]      w_req;
    logic [NC-1:0]      w_clr;
    logic [NC-1:0]      w_revert;
    logic [NC-1:0]      w_unasg;
    logic [NC-1:0]      w_unasg_d;

    logic [CSTW-1:0]    w_cost [N_LIFTS];
    logic [N_LIFTS-1:0] w_door_here;
    logic               w_found;
    logic [LW-1:0]      w_best_lift;
    logic [CSTW-1:0]    w_best_cost;
    logic               w_offer_clr;
    logic               w_accept;

    assign w_req        = {dn_rqst & DN_MASK, up_rqst & UP_MASK};
    assign w_ptr_idx    = (ptr_dn_q ? CW'(N_FLOORS) : CW'(0)) + CW'(ptr_fl_q);
    assign w_ptr_fl_nxt = (ptr_fl_q == LAST_FLOOR) ? '0 : ptr_fl_q + 1'b1;
    assign w_ptr_dn_nxt = (ptr_fl_q == LAST_FLOOR) ? ~ptr_dn_q : ptr_dn_q;
    assign w_unasg      = pend_q & ~asg_q;
    assign w_unasg_d    = pend_d & ~asg_d;

    // The offered call disappears if any lift opens doors at its floor.
    assign w_offer_clr  = (state_q == ST_OFFER) && (|w_door_here);
    assign w_accept     = (state_q == ST_OFFER) && assign_ready && !w_offer_clr;

    // Per-entry clear (owner serving the floor) and revert (owner disabled).
    for (genvar c = 0; c < NC; c++) begin : g_entry
        localparam logic [FW-1:0] ENT_FLOOR = FW'(c % N_FLOORS);
        assign w_clr[c]    = pend_q[c] & asg_q[c] & door_open[owner_q[c]]
                           & (lift_floor[owner_q[c]] == ENT_FLOOR);
        assign w_revert[c] = asg_q[c] & ~lift_enable[owner_q[c]];
    end

    // Per-lift cost toward the call under the scan pointer.
    for (genvar l = 0; l < N_LIFTS; l++) begin : g_lift
        logic [CSTW-1:0] w_lf;
        logic [CSTW-1:0] w_fl;
        logic [CSTW-1:0] w_dist;
        logic            w_away;
        logic            w_pen;
        assign w_lf           = {1'b0, lift_floor[l]};
        assign w_fl           = {1'b0, ptr_fl_q};
        assign w_dist         = (w_lf >= w_fl) ? (w_lf - w_fl) : (w_fl - w_lf);
        assign w_away         = direction[l] ? (w_lf > w_fl) : (w_lf < w_fl);
        assign w_pen          = motion[l] & (w_away | (direction[l] != ~ptr_dn_q));
        assign w_cost[l]      = w_dist + (w_pen ? PENALTY : '0);
        assign w_door_here[l] = door_open[l] & (lift_floor[l] == ptr_fl_q);
    end

    // Minimum-cost enabled lift; strict compare keeps the lowest index on ties.
    always_comb begin
        w_found     = 1'b0;
        w_best_lift = '0;
        w_best_cost = '1;
        for (int l = 0; l < N_LIFTS; l++) begin
            if (lift_enable[l] && (!w_found || (w_cost[l] < w_best_cost))) begin
                w_found     = 1'b1;
                w_best_cost = w_cost[l];
                w_best_lift = LW'(l);
            end
        end
    end

    // Next call-table state: set, revert, accept, then clear (clear wins).
    always_comb begin
        pend_d = pend_q;
        asg_d  = asg_q;
        for (int c = 0; c < NC; c++) begin
            owner_d[c] = owner_q[c];
            if (w_req[c] && !pend_q[c]) begin
                pend_d[c] = 1'b1;
                asg_d[c]  = 1'b0;
            end
            if (w_revert[c]) begin
                asg_d[c] = 1'b0;
            end
            if (w_accept && (CW'(c) == w_ptr_idx)) begin
                asg_d[c]   = 1'b1;
                owner_d[c] = lift_q;
            end
            if (w_clr[c] || (w_offer_clr && (CW'(c) == w_ptr_idx))) begin
                pend_d[c] = 1'b0;
                asg_d[c]  = 1'b0;
            end
        end
    end

    // Call table registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            asg_q  <= '0;
            for (int c = 0; c < NC; c++) begin
                owner_q[c] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            asg_q  <= asg_d;
            for (int c = 0; c < NC; c++) begin
                owner_q[c] <= owner_d[c];
            end
        end
    end

    // Dispatch FSM with registered offer outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_dn_q <= 1'b0;
            ptr_fl_q <= '0;
            valid_q  <= 1'b0;
            lift_q   <= '0;
            floor_q  <= '0;
            up_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|w_unasg_d) begin
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_unasg[w_ptr_idx]) begin
                        state_q <= ST_EVAL;
                    end else if (!(|w_unasg)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        ptr_dn_q <= w_ptr_dn_nxt;
                        ptr_fl_q <= w_ptr_fl_nxt;
                    end
                end
                ST_EVAL: begin
                    if (w_found) begin
                        lift_q  <= w_best_lift;
                        floor_q <= ptr_fl_q;
                        up_q    <= ~ptr_dn_q;
                        valid_q <= 1'b1;
                        state_q <= ST_OFFER;
                    end else begin
                        ptr_dn_q <= w_ptr_dn_nxt;
                        ptr_fl_q <= w_ptr_fl_nxt;
                        state_q  <= ST_SCAN;
                    end
                end
                ST_OFFER: begin
                    if (w_offer_clr || assign_ready) begin
                        valid_q  <= 1'b0;
                        ptr_dn_q <= w_ptr_dn_nxt;
                        ptr_fl_q <= w_ptr_fl_nxt;
                        state_q  <= ST_SCAN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign assign_valid = valid_q;
    assign assign_lift  = lift_q;
    assign assign_floor = floor_q;
    assign assign_up    = up_q;
    assign pending_up   = pend_q[N_FLOORS-1:0];
    assign pending_dn   = pend_q[NC-1:N_FLOORS];

endmodule
`default_nettype wire

// File: tb/tb_hall_call_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_hall_call_dispatcher
// Description : Self-checking bench for hall_call_dispatcher: a table of
//               lift-selection vectors plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hall_call_dispatcher;

    logic             clk;
    logic             reset;
    logic [11:0]      up_rqst;
    logic [11:0]      dn_rqst;
    logic [9:0][3:0]  lift_floor;
    logic [9:0]       direction;
    logic [9:0]       motion;
    logic [9:0]       door_open;
    logic [9:0]       lift_enable;
    logic             assign_valid;
    logic             assign_ready;
    logic [3:0]       assign_lift;
    logic [3:0]       assign_floor;
    logic             assign_up;
    logic [11:0]      pending_up;
    logic [11:0]      pending_dn;

    int n_chk;
    int n_fail;

    hall_call_dispatcher #(.N_FLOORS(12), .N_LIFTS(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .up_rqst      (up_rqst),
        .dn_rqst      (dn_rqst),
        .lift_floor   (lift_floor),
        .direction    (direction),
        .motion       (motion),
        .door_open    (door_open),
        .lift_enable  (lift_enable),
        .assign_valid (assign_valid),
        .assign_ready (assign_ready),
        .assign_lift  (assign_lift),
        .assign_floor (assign_floor),
        .assign_up    (assign_up),
        .pending_up   (pending_up),
        .pending_dn   (pending_dn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0][3:0] lf;
        logic [9:0]      en;
        logic [9:0]      dr;
        logic [9:0]      mo;
        int              fl;
        bit              up;
        bit              exp_v;
        int              exp_l;
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mk(input logic [9:0] en, input logic [9:0] dr,
                                input logic [9:0] mo, input int fl, input bit up,
                                input bit ev, input int el);
        vec_t v;
        v.lf    = '0;
        v.en    = en;
        v.dr    = dr;
        v.mo    = mo;
        v.fl    = fl;
        v.up    = up;
        v.exp_v = ev;
        v.exp_l = el;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output bit got);
        int i;
        i = 0;
        while (!assign_valid && i < budget) begin
            step();
            i++;
        end
        got = assign_valid;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        up_rqst      = '0;
        dn_rqst      = '0;
        door_open    = '0;
        assign_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic set_lifts(input logic [9:0] en, input logic [9:0] dr, input logic [9:0] mo);
        lift_enable = en;
        direction   = dr;
        motion      = mo;
    endtask

    initial begin
        bit got;
        logic [3:0] exp_fl [3];
        logic       exp_up [3];
        n_chk = 0;
        n_fail = 0;
        up_rqst = '0; dn_rqst = '0; lift_floor = '0; direction = '0;
        motion = '0; door_open = '0; lift_enable = '0; assign_ready = 1'b0;
        reset = 1'b0;

        // Lift-selection vectors
        vecs[0] = mk(10'b0000000011, 10'b0, 10'b0, 4, 1, 1, 1);
        vecs[0].lf[1] = 4'd5;
        vecs[1] = mk(10'b0000000011, 10'b0, 10'b0000000001, 5, 1, 1, 1);
        vecs[1].lf[0] = 4'd3; vecs[1].lf[1] = 4'd7;
        vecs[2] = mk(10'b0000100100, 10'b0, 10'b0, 6, 0, 1, 2);
        vecs[2].lf[2] = 4'd6; vecs[2].lf[5] = 4'd6;
        vecs[3] = mk(10'b0000100000, 10'b0, 10'b0, 6, 0, 1, 5);
        vecs[3].lf[2] = 4'd6; vecs[3].lf[5] = 4'd6;
        vecs[4] = mk(10'b0000000000, 10'b0, 10'b0, 6, 0, 0, 0);
        vecs[5] = mk(10'b0000011000, 10'b0000001000, 10'b0000001000, 5, 1, 1, 3);
        vecs[5].lf[3] = 4'd4; vecs[5].lf[4] = 4'd7;
        vecs[6] = mk(10'b0000011000, 10'b0000001000, 10'b0000001000, 5, 0, 1, 4);
        vecs[6].lf[3] = 4'd4; vecs[6].lf[4] = 4'd7;
        vecs[7] = mk(10'b0001000100, 10'b0, 10'b0001000000, 9, 0, 1, 6);
        vecs[7].lf[6] = 4'd9; vecs[7].lf[2] = 4'd8;
        vecs[8] = mk(10'b1000000000, 10'b0, 10'b0, 11, 0, 1, 9);

        // Reset state
        do_reset();
        chk("reset valid", assign_valid, 0);
        chk("reset lift", assign_lift, 0);
        chk("reset floor", assign_floor, 0);
        chk("reset up", assign_up, 0);
        chk("reset pending_up", pending_up, 0);
        chk("reset pending_dn", pending_dn, 0);

        // Minimum latency from an empty table: call on entry 0
        set_lifts(10'b1, 10'b0, 10'b0);
        lift_floor = '0;
        up_rqst[0] = 1'b1;
        step();
        up_rqst = '0;
        chk("lat pending", pending_up, 12'h001);
        chk("lat valid t+1", assign_valid, 0);
        step();
        chk("lat valid t+2", assign_valid, 0);
        step();
        chk("lat valid t+3", assign_valid, 1);
        chk("lat floor", assign_floor, 0);
        chk("lat up", assign_up, 1);

        // Table-driven selection vectors
        for (int i = 0; i < 9; i++) begin
            do_reset();
            lift_floor = vecs[i].lf;
            set_lifts(vecs[i].en, vecs[i].dr, vecs[i].mo);
            if (vecs[i].up) up_rqst[vecs[i].fl] = 1'b1;
            else            dn_rqst[vecs[i].fl] = 1'b1;
            step();
            up_rqst = '0;
            dn_rqst = '0;
            chk($sformatf("vec%0d pending", i),
                vecs[i].up ? pending_up[vecs[i].fl] : pending_dn[vecs[i].fl], 1);
            wait_valid(40, got);
            chk($sformatf("vec%0d valid", i), got, vecs[i].exp_v);
            if (vecs[i].exp_v) begin
                chk($sformatf("vec%0d lift", i), assign_lift, vecs[i].exp_l);
                chk($sformatf("vec%0d floor", i), assign_floor, vecs[i].fl);
                chk($sformatf("vec%0d up", i), assign_up, vecs[i].up);
            end else begin
                chk($sformatf("vec%0d still pending", i),
                    vecs[i].up ? pending_up[vecs[i].fl] : pending_dn[vecs[i].fl], 1);
            end
        end

        // Single call: accept, hold until owner opens doors at the floor
        do_reset();
        lift_floor = '0;
        lift_floor[1] = 4'd5;
        set_lifts(10'b11, 10'b0, 10'b0);
        up_rqst[4] = 1'b1;
        step();
        up_rqst = '0;
        wait_valid(40, got);
        chk("single valid", got, 1);
        chk("single lift", assign_lift, 1);
        assign_ready = 1'b1;
        step();
        assign_ready = 1'b0;
        chk("single valid drop", assign_valid, 0);
        repeat (5) step();
        chk("single held", pending_up, 12'h010);
        door_open[1] = 1'b1;
        step();
        chk("single wrong floor", pending_up, 12'h010);
        lift_floor[1] = 4'd4;
        step();
        door_open = '0;
        chk("single cleared", pending_up, 12'h000);
        step();
        chk("single no reoffer", assign_valid, 0);

        // Backpressure: offer held stable, then withdrawn when another lift serves it
        do_reset();
        lift_floor = '0;
        lift_floor[1] = 4'd5;
        set_lifts(10'b11, 10'b0, 10'b0);
        up_rqst[4] = 1'b1;
        step();
        up_rqst = '0;
        wait_valid(40, got);
        chk("bp valid", got, 1);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) lift_floor[0] = 4'd4;
            step();
            chk($sformatf("bp hold%0d", k),
                {assign_valid, assign_lift, assign_floor, assign_up}, {1'b1, 4'd1, 4'd4, 1'b1});
        end
        door_open[0] = 1'b1;
        step();
        door_open = '0;
        chk("bp withdrawn", assign_valid, 0);
        chk("bp pending cleared", pending_up, 12'h000);
        repeat (4) step();
        chk("bp stays idle", assign_valid, 0);

        // Round robin in table order, then owner clears during a re-press
        do_reset();
        lift_floor = '0;
        set_lifts(10'b1, 10'b0, 10'b0);
        up_rqst[1] = 1'b1; up_rqst[9] = 1'b1; dn_rqst[9] = 1'b1;
        step();
        up_rqst = '0; dn_rqst = '0;
        chk("rr pending_up", pending_up, 12'h202);
        chk("rr pending_dn", pending_dn, 12'h200);
        exp_fl[0] = 4'd1; exp_up[0] = 1'b1;
        exp_fl[1] = 4'd9; exp_up[1] = 1'b1;
        exp_fl[2] = 4'd9; exp_up[2] = 1'b0;
        assign_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid(40, got);
            chk($sformatf("rr%0d valid", k), got, 1);
            chk($sformatf("rr%0d floor", k), assign_floor, exp_fl[k]);
            chk($sformatf("rr%0d up", k), assign_up, exp_up[k]);
            step();
        end
        assign_ready = 1'b0;
        lift_floor[0] = 4'd9;
        door_open[0] = 1'b1;
        dn_rqst[9] = 1'b1;
        step();
        door_open = '0;
        dn_rqst = '0;
        chk("rr dn9 cleared", pending_dn, 12'h000);
        chk("rr up9 cleared", pending_up, 12'h002);
        step();
        chk("rr dn9 stays clear", pending_dn, 12'h000);

        // Owner disabled: call reverts and is re-offered to another lift
        do_reset();
        lift_floor = '0;
        lift_floor[1] = 4'd8;
        set_lifts(10'b11, 10'b0, 10'b0);
        up_rqst[2] = 1'b1;
        step();
        up_rqst = '0;
        wait_valid(40, got);
        chk("rev first valid", got, 1);
        chk("rev first lift", assign_lift, 0);
        assign_ready = 1'b1;
        step();
        assign_ready = 1'b0;
        lift_enable = 10'b10;
        wait_valid(60, got);
        chk("rev reoffer valid", got, 1);
        chk("rev reoffer lift", assign_lift, 1);
        chk("rev reoffer floor", assign_floor, 2);
        chk("rev still pending", pending_up, 12'h004);

        // Reset during OFFER, then ignored button bits
        do_reset();
        lift_floor = '0;
        set_lifts(10'b1, 10'b0, 10'b0);
        up_rqst[3] = 1'b1;
        dn_rqst[5] = 1'b1;
        step();
        up_rqst = '0; dn_rqst = '0;
        wait_valid(40, got);
        chk("rst offer valid", got, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst valid", assign_valid, 0);
        chk("rst fields", {assign_lift, assign_floor, assign_up}, 9'd0);
        chk("rst pending", {pending_up, pending_dn}, 24'd0);
        up_rqst[11] = 1'b1;
        dn_rqst[0]  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("ignored%0d pending", k), {pending_up, pending_dn}, 24'd0);
        end
        up_rqst = '0; dn_rqst = '0;
        repeat (5) step();
        chk("ignored no valid", assign_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
